// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative MULT(U)/DIV(U) over WIDTH steps plus single-cycle MTHI/MTLO.
// Owns the architectural HI/LO registers and raises busy while an iterative op is in flight.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] work_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic               is_div_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;
    logic               div_zero_reg;

    logic               is_mul_op, is_div_op, is_signed_op, launch;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    always_comb begin
        is_mul_op    = (alucontrol == OP_MULTU) || (alucontrol == OP_MULT);
        is_div_op    = (alucontrol == OP_DIVU) || (alucontrol == OP_DIV);
        is_signed_op = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
        launch       = start && (state_reg == IDLE) && (is_mul_op || is_div_op);
        a_neg        = is_signed_op && srca[WIDTH-1];
        b_neg        = is_signed_op && srcb[WIDTH-1];
        a_abs        = a_neg ? -srca : srca;
        b_abs        = b_neg ? -srcb : srcb;
    end

    // work_reg holds {accumulator, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        mul_addend = work_reg[0] ? operand_reg : '0;
        mul_sum    = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_trial  = work_reg[2*WIDTH-1:WIDTH-1] - {1'b0, operand_reg};
        if (!is_div_reg)
            step_next = {mul_sum, work_reg[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            step_next = {work_reg[2*WIDTH-2:0], 1'b0};
        else
            step_next = {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
    end

    // A zero divisor leaves |dividend| as remainder, so negating restores the raw dividend.
    always_comb begin
        prod_fixed = neg_lo_reg ? -work_reg : work_reg;
        quot_fixed = div_zero_reg ? '1 :
                     (neg_lo_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0]);
        rem_fixed  = neg_hi_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = CALC;
            CALC:    if (count_reg == CW'(WIDTH)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi           <= '0;
            lo           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count_reg    <= '0;
            work_reg     <= '0;
            operand_reg  <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        operand_reg  <= is_div_op ? b_abs : a_abs;
                        work_reg     <= {{WIDTH{1'b0}}, (is_div_op ? a_abs : b_abs)};
                        is_div_reg   <= is_div_op;
                        neg_lo_reg   <= a_neg ^ b_neg;
                        neg_hi_reg   <= is_div_op && a_neg;
                        div_zero_reg <= is_div_op && (srcb == '0);
                        count_reg    <= '0;
                        busy         <= 1'b1;
                    end else if (start && alucontrol == OP_MTHI) begin
                        hi <= srca;
                    end else if (start && alucontrol == OP_MTLO) begin
                        lo <= srca;
                    end
                end
                CALC: begin
                    if (count_reg != CW'(WIDTH)) begin
                        work_reg  <= step_next;
                        count_reg <= count_reg + 1'b1;
                    end
                end
                FIX: begin
                    if (is_div_reg) begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
